// File: rtl/serial_pattern_ctrl.sv
// serial_pattern_ctrl: run controller for serial bit-pattern detection.
//
// Latches a pattern of up to PAT_W bits and searches a qualified serial
// stream for it. Overlapping matches are counted. Each match is reported
// through a valid/ready event port that carries the bit position. An
// optional hold-off window after each match suppresses further matches.
//
// Optional feature macro: SERIAL_PATTERN_HOLDOFF_EN (HOLDOFF state and
// hold-off counter). When it is undefined, cfg_holdoff is ignored.
//
// Ports:
//   sys_clk, rst            clock; asynchronous active-high reset
//   cfg_pattern/len/holdoff/target
//                           search configuration, latched on start
//   start, abort            single-cycle arm / stop requests
//   dat_in, dat_vld         serial bit and its qualifier
//   busy, done              run status (HUNT/HOLDOFF, DONE)
//   match_cnt               saturating match count since start
//   evt_valid, evt_ready    match event handshake
//   evt_pos                 bit index of the bit that completed the match
//   overflow                sticky: match seen while an event was pending
module serial_pattern_ctrl #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [3:0]       cfg_len,
    input  logic [3:0]       cfg_holdoff,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic             start,
    input  logic             abort,
    input  logic             dat_in,
    input  logic             dat_vld,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_cnt,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [15:0]      evt_pos,
    output logic             overflow
);

    localparam logic [3:0] PAT_LEN = 4'(PAT_W);

    typedef enum logic [1:0] {StIdle, StHunt, StHoldoff, StDone} state_t;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [3:0]       len_q, len_d;
    logic [CNT_W-1:0] target_q, target_d;
    // Only the newest PAT_W-1 bits are stored; the incoming bit completes
    // the PAT_W-wide window that is compared.
    logic [PAT_W-2:0] sh_q, sh_d;
    logic [3:0]       fill_q, fill_d;
    logic [15:0]      idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             evt_valid_q, evt_valid_d;
    logic [15:0]      evt_pos_q, evt_pos_d;
    logic             overflow_q, overflow_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SERIAL_PATTERN_HOLDOFF_EN
    logic [3:0]       hold_cfg_q, hold_cfg_d;
    logic [3:0]       hold_q, hold_d;
`else
    logic             unused_holdoff;
    assign unused_holdoff = ^cfg_holdoff;
`endif

    logic [PAT_W-1:0] sh_post;
    logic [PAT_W-1:0] mask;
    logic [3:0]       fill_post;
    logic [3:0]       len_clamp;
    logic [CNT_W-1:0] cnt_inc;
    logic             hit;

    always_comb begin
        sh_post   = {sh_q, dat_in};
        fill_post = (fill_q == PAT_LEN) ? PAT_LEN : fill_q + 4'd1;
        len_clamp = (cfg_len == 4'd0) ? 4'd1 : ((cfg_len > PAT_LEN) ? PAT_LEN : cfg_len);
        cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        mask      = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (i < int'(len_q));
        end
        hit = (state_q == StHunt) && dat_vld && (((sh_post ^ pat_q) & mask) == '0) &&
              (fill_post >= len_q);

        state_d     = state_q;
        pat_d       = pat_q;
        len_d       = len_q;
        target_d    = target_q;
        sh_d        = sh_q;
        fill_d      = fill_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        evt_valid_d = evt_valid_q;
        evt_pos_d   = evt_pos_q;
        overflow_d  = overflow_q;
`ifdef SERIAL_PATTERN_HOLDOFF_EN
        hold_cfg_d  = hold_cfg_q;
        hold_d      = hold_q;
`endif

        if (evt_valid_q && evt_ready) begin
            evt_valid_d = 1'b0;
        end

        if (abort) begin
            state_d     = StIdle;
            evt_valid_d = 1'b0;
`ifdef SERIAL_PATTERN_HOLDOFF_EN
            hold_d      = 4'd0;
`endif
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_d     = StHunt;
                        pat_d       = cfg_pattern;
                        len_d       = len_clamp;
                        target_d    = cfg_target;
                        sh_d        = '0;
                        fill_d      = 4'd0;
                        idx_d       = 16'd0;
                        cnt_d       = '0;
                        evt_valid_d = 1'b0;
                        overflow_d  = 1'b0;
`ifdef SERIAL_PATTERN_HOLDOFF_EN
                        hold_cfg_d  = cfg_holdoff;
`endif
                    end
                end
                StHunt, StHoldoff: begin
                    if (dat_vld) begin
                        sh_d   = sh_post[PAT_W-2:0];
                        fill_d = fill_post;
                        idx_d  = idx_q + 16'd1;
`ifdef SERIAL_PATTERN_HOLDOFF_EN
                        if (state_q == StHoldoff) begin
                            hold_d = hold_q - 4'd1;
                            if (hold_q == 4'd1) begin
                                state_d = StHunt;
                            end
                        end
`endif
                        if (hit) begin
                            cnt_d = cnt_inc;
                            // A pending, unaccepted event keeps its position;
                            // the newer match is only counted and flagged.
                            if (evt_valid_q && !evt_ready) begin
                                overflow_d = 1'b1;
                            end else begin
                                evt_valid_d = 1'b1;
                                evt_pos_d   = idx_q;
                            end
                            if ((target_q != '0) && (cnt_inc == target_q)) begin
                                state_d = StDone;
                            end
`ifdef SERIAL_PATTERN_HOLDOFF_EN
                            else if (hold_cfg_q != 4'd0) begin
                                hold_d  = hold_cfg_q;
                                state_d = StHoldoff;
                            end
`endif
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        busy_d = (state_d == StHunt) || (state_d == StHoldoff);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            pat_q       <= '0;
            len_q       <= 4'd1;
            target_q    <= '0;
            sh_q        <= '0;
            fill_q      <= 4'd0;
            idx_q       <= 16'd0;
            cnt_q       <= '0;
            evt_valid_q <= 1'b0;
            evt_pos_q   <= 16'd0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef SERIAL_PATTERN_HOLDOFF_EN
            hold_cfg_q  <= 4'd0;
            hold_q      <= 4'd0;
`endif
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            len_q       <= len_d;
            target_q    <= target_d;
            sh_q        <= sh_d;
            fill_q      <= fill_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            evt_valid_q <= evt_valid_d;
            evt_pos_q   <= evt_pos_d;
            overflow_q  <= overflow_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef SERIAL_PATTERN_HOLDOFF_EN
            hold_cfg_q  <= hold_cfg_d;
            hold_q      <= hold_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign match_cnt = cnt_q;
    assign evt_valid = evt_valid_q;
    assign evt_pos   = evt_pos_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_pattern_ctrl.sv
// Self-checking bench for serial_pattern_ctrl. Expected event positions are
// queued as each directed stream is issued; a negedge monitor pops and
// compares on every accepted event. Status outputs are checked directly.
module tb_serial_pattern_ctrl;

    logic        sys_clk;
    logic        rst;
    logic [7:0]  cfg_pattern;
    logic [3:0]  cfg_len;
    logic [3:0]  cfg_holdoff;
    logic [7:0]  cfg_target;
    logic        start;
    logic        abort;
    logic        dat_in;
    logic        dat_vld;
    logic        busy;
    logic        done;
    logic [7:0]  match_cnt;
    logic        evt_valid;
    logic        evt_ready;
    logic [15:0] evt_pos;
    logic        overflow;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_pos;

    serial_pattern_ctrl #(.PAT_W(8), .CNT_W(8)) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_holdoff (cfg_holdoff),
        .cfg_target  (cfg_target),
        .start       (start),
        .abort       (abort),
        .dat_in      (dat_in),
        .dat_vld     (dat_vld),
        .busy        (busy),
        .done        (done),
        .match_cnt   (match_cnt),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_pos     (evt_pos),
        .overflow    (overflow)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Each negedge with valid && ready is exactly one accepted event.
    always @(negedge sys_clk) begin
        if (evt_valid && evt_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL evt_unexpected pos=%0d required=none", evt_pos);
            end else begin
                exp_pos = exp_q.pop_front();
                if (evt_pos !== exp_pos) begin
                    errors++;
                    $display("FAIL evt_pos got=%0d required=%0d", evt_pos, exp_pos);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send(input logic b);
        dat_in  = b;
        dat_vld = 1'b1;
        tick();
        dat_vld = 1'b0;
    endtask

    // Sends bits[n-1] first.
    task automatic send_bits(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            send(bits[i]);
        end
    endtask

    task automatic arm(input logic [7:0] pat, input logic [3:0] len,
                       input logic [3:0] hold, input logic [7:0] tgt);
        abort = 1'b1;
        tick();
        abort       = 1'b0;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_holdoff = hold;
        cfg_target  = tgt;
        start       = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        cfg_pattern = 8'h00;
        cfg_len     = 4'd0;
        cfg_holdoff = 4'd0;
        cfg_target  = 8'd0;
        start       = 1'b0;
        abort       = 1'b0;
        dat_in      = 1'b0;
        dat_vld     = 1'b0;
        evt_ready   = 1'b1;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cnt", match_cnt, 0);
        check("rst_valid", evt_valid, 0);
        check("rst_pos", evt_pos, 0);
        check("rst_ovf", overflow, 0);
        rst = 1'b0;
        tick();

        // Overlapping matches at 3 and 6.
        exp_q.push_back(16'd3);
        exp_q.push_back(16'd6);
        arm(8'b0000_1101, 4'd4, 4'd0, 8'd0);
        check("ovl_busy_after_start", busy, 1);
        send_bits(16'b1101101, 7);
        check("ovl_cnt", match_cnt, 2);
        check("ovl_busy", busy, 1);
        tick();

        // Hold-off 3 swallows the overlap (unless the feature is built out).
        exp_q.push_back(16'd3);
`ifndef SERIAL_PATTERN_HOLDOFF_EN
        exp_q.push_back(16'd6);
`endif
        arm(8'b0000_1101, 4'd4, 4'd3, 8'd0);
        send_bits(16'b1101101, 7);
`ifdef SERIAL_PATTERN_HOLDOFF_EN
        check("hold3_cnt", match_cnt, 1);
`else
        check("hold3_cnt", match_cnt, 2);
`endif
        check("hold3_busy", busy, 1);
        tick();

        // Hold-off 2: bit k+H+1 may match again.
        exp_q.push_back(16'd3);
        exp_q.push_back(16'd6);
        arm(8'b0000_1101, 4'd4, 4'd2, 8'd0);
        send_bits(16'b1101101, 7);
        check("hold2_cnt", match_cnt, 2);
        tick();

        // Fill guard with dat_vld gaps: zero pattern cannot hit before 4 bits.
        exp_q.push_back(16'd3);
        exp_q.push_back(16'd4);
        arm(8'h00, 4'd4, 4'd0, 8'd0);
        send(1'b0);
        tick();
        tick();
        send(1'b0);
        tick();
        send(1'b0);
        check("fill_cnt_early", match_cnt, 0);
        send(1'b0);
        send(1'b0);
        check("fill_cnt", match_cnt, 2);
        tick();

        // Length 0 clamps to 1.
        exp_q.push_back(16'd1);
        arm(8'h01, 4'd0, 4'd0, 8'd0);
        send_bits(16'b01, 2);
        check("len0_cnt", match_cnt, 1);
        tick();

        // Length 12 clamps to 8.
        exp_q.push_back(16'd7);
        arm(8'hA5, 4'd12, 4'd0, 8'd0);
        send_bits(16'hA5, 8);
        check("len12_cnt", match_cnt, 1);
        tick();

        // Target 2 -> DONE; later bits are ignored; start from DONE re-arms.
        exp_q.push_back(16'd3);
        exp_q.push_back(16'd6);
        arm(8'b0000_1101, 4'd4, 4'd0, 8'd2);
        send_bits(16'b1101101, 7);
        check("tgt_done", done, 1);
        check("tgt_busy", busy, 0);
        check("tgt_cnt", match_cnt, 2);
        send_bits(16'b1101, 4);
        check("tgt_cnt_hold", match_cnt, 2);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_cnt", match_cnt, 0);
        check("restart_busy", busy, 1);
        check("restart_done", done, 0);

        // Overflow: second match while the first is unaccepted.
        evt_ready = 1'b0;
        arm(8'b0000_1101, 4'd4, 4'd0, 8'd0);
        send_bits(16'b1101101, 7);
        check("ovf_valid", evt_valid, 1);
        check("ovf_pos", evt_pos, 3);
        check("ovf_flag", overflow, 1);
        check("ovf_cnt", match_cnt, 2);
        exp_q.push_back(16'd3);
        evt_ready = 1'b1;
        tick();
        check("ovf_valid_clr", evt_valid, 0);
        check("ovf_sticky", overflow, 1);
        arm(8'b0000_1101, 4'd4, 4'd0, 8'd0);
        check("ovf_cleared_by_start", overflow, 0);

        // Abort during hold-off (hunt when built out).
        evt_ready = 1'b0;
        arm(8'b0000_1101, 4'd4, 4'd5, 8'd0);
        send_bits(16'b1101, 4);
        check("abt_valid_pre", evt_valid, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abt_busy", busy, 0);
        check("abt_valid", evt_valid, 0);
        check("abt_cnt", match_cnt, 1);

        // Asynchronous reset in the middle of a hunt.
        arm(8'b0000_1101, 4'd4, 4'd0, 8'd0);
        send_bits(16'b1101, 4);
        @(posedge sys_clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_cnt", match_cnt, 0);
        check("arst_valid", evt_valid, 0);
        check("arst_pos", evt_pos, 0);
        check("arst_ovf", overflow, 0);
        #1;
        rst = 1'b0;
        tick();
        evt_ready = 1'b1;

        // Abort wins over start.
        cfg_pattern = 8'b0000_1101;
        cfg_len     = 4'd4;
        abort       = 1'b1;
        start       = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("abt_start_busy", busy, 0);
        check("abt_start_done", done, 0);

        tick();
        tick();
        check("evt_queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
